btn_conditioner: RTL and testbench
==================================

# btn_conditioner

Front-end conditioner for the four blackjack action push-buttons (next, hit, stand, double) on the Basys 3 board. It sits directly upstream of the game top and the seven-segment display controller. It synchronises each raw pad signal, debounces it, and turns each accepted press into a single-cycle action pulse. An arbitration lockout guarantees at most one action per physical press episode, so game-state logic never sees bounce, repeats or overlapping actions.

## Interface
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a level change (10 ms at 100 MHz); legal range ≥ 2
- clk  input  1  100 MHz system clock
- reset  input  1  reset, synchronous, active-high
- next_raw  input  1  raw pad level, asynchronous, active-high
- hit_raw  input  1  raw pad level, asynchronous, active-high
- stand_raw  input  1  raw pad level, asynchronous, active-high
- double_raw  input  1  raw pad level, asynchronous, active-high
- next_p  output  1  one-cycle pulse: accepted next press
- hit_p  output  1  one-cycle pulse: accepted hit press
- stand_p  output  1  one-cycle pulse: accepted stand press
- double_p  output  1  one-cycle pulse: accepted double press
- btn_level  output  4  debounced levels {double, stand, hit, next}
- locked  output  1  high while in HOLD (press accepted, waiting for all-release)

## Operation
- Synchroniser:
  - Two flops per raw input.
  - The second flop's output is the synchronised level s[i].
- Debounce, per button:
  - Counter width $clog2(DEBOUNCE_CYCLES).
  - If s[i] == stable[i], the counter clears to 0.
  - Otherwise the counter increments.
  - When the counter equals DEBOUNCE_CYCLES-1 and s[i] still differs, stable[i] <= s[i] and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles restarts the count; stable[i] does not change.
- Edge detect: rise[i] = stable[i] & ~stable_d[i], where stable_d is stable delayed one cycle.
- Arbitration FSM, two states:
  - IDLE: if any rise[i] is set, register exactly one pulse, then go to HOLD.
    - Priority when several rises coincide: next > stand > hit > double.
    - Losing rises are discarded, not queued.
  - HOLD: no pulses are generated; all rises are discarded.
    - Return to IDLE in the cycle after btn_level == 4'b0000.
- Pulses are registered and high for exactly one cycle. At most one of the four pulses is high in any cycle.
- Release edges never generate pulses.
- btn_level = stable.
- locked = (state == HOLD).

## Timing
- Reset (synchronous, any time, including mid-debounce or in HOLD):
  - All synchroniser flops, counters, stable, stable_d and pulse registers clear to 0.
  - FSM goes to IDLE.
  - Outputs after the reset edge: all pulses 0, btn_level 0, locked 0.
- A button held across reset release counts as a new press: it is debounced from 0 and yields one pulse.
- Press latency, with edge 1 = first clock edge sampling a new raw level held steady:
  - s[i] = 1 after edge 2.
  - stable[i] = 1 after edge DEBOUNCE_CYCLES+2.
  - Pulse high after edge DEBOUNCE_CYCLES+3, low after edge DEBOUNCE_CYCLES+4.
- Release latency: stable[i] falls after edge DEBOUNCE_CYCLES+2 from the first low sample.
- Lockout exit: FSM re-enters IDLE one edge after btn_level reaches 0. A rise in that same cycle is discarded.
- Arbitration adds no latency beyond the single pulse register.

## Test plan
DEBOUNCE_CYCLES = 4 in all scenarios.
- Clean press: hit_raw 0→1, held 20 cycles → hit_p high exactly in the cycle after edge 7; locked=1 from the same edge; btn_level=4'b0010; no other pulse.
- Bounce: next_raw toggles 1,0,1,0 on successive cycles, then holds 1 → no pulse during toggling; single next_p 7 edges after the final rise; release with bounce → no pulse.
- Simultaneous press: stand_raw and hit_raw rise on the same cycle → stand_p only; hit_p never asserts; locked until both released.
- Lockout: hit pressed and held, double pressed later while hit is held → double_p never asserts; after full release and a fresh double press → double_p pulses once.
- Glitch: double_raw high for 3 cycles only → btn_level stays 0, no pulse, locked stays 0.
- Reset mid-operation: assert reset for 1 cycle at edge 5 of a next press (raw still high) → outputs 0 immediately after the edge; next_p appears 7 edges after reset deasserts; a pulse pending at the reset edge is lost.

Source files
------------

// File: rtl/btn_conditioner.sv
// btn_conditioner
//   Conditions the four blackjack action buttons. Each raw pad goes through a
//   two-flop synchroniser and a per-button debouncer. Rising edges of the
//   debounced levels feed a lockout arbiter. The arbiter emits at most one
//   single-cycle action pulse per press episode. It then stays locked until
//   every button has been released.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high reset
//   *_raw        asynchronous raw pad levels (next, hit, stand, double)
//   *_p          one-cycle accepted-press pulses
//   btn_level    debounced levels {double, stand, hit, next}
//   locked       high while a press has been accepted and not all released
//
// Arbiter states
//   state | meaning
//   IDLE  | waiting for a debounced rising edge on any button
//   HOLD  | a press was accepted; ignore everything until all released

module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       next_raw,
  input  logic       hit_raw,
  input  logic       stand_raw,
  input  logic       double_raw,
  output logic       next_p,
  output logic       hit_p,
  output logic       stand_p,
  output logic       double_p,
  output logic [3:0] btn_level,
  output logic       locked
);

  localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  // Bit order everywhere: {double, stand, hit, next}
  logic [3:0] raw_vec;

  logic [3:0]    sync1_q, sync1_d;
  logic [3:0]    sync2_q, sync2_d;
  logic [3:0]    stable_q, stable_d;
  logic [3:0]    stable_dly_q, stable_dly_d;
  logic [CW-1:0] cnt_q [4];
  logic [CW-1:0] cnt_d [4];
  logic [3:0]    rise;
  logic [3:0]    pulse_q, pulse_d;
  state_t        state_q, state_d;

  assign raw_vec = {double_raw, stand_raw, hit_raw, next_raw};

  // Synchroniser, debounce and edge-detect datapath
  always_comb begin
    sync1_d      = raw_vec;
    sync2_d      = sync1_q;
    stable_d     = stable_q;
    stable_dly_d = stable_q;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = '0;
      // The counter only runs while the synchronised level disagrees with
      // the accepted level; any agreeing sample restarts the qualification.
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign rise = stable_q & ~stable_dly_q;

  // Arbiter: next > stand > hit > double; losers are dropped, not queued
  always_comb begin
    state_d = state_q;
    pulse_d = 4'b0000;
    case (state_q)
      ST_IDLE: begin
        if (|rise) begin
          state_d = ST_HOLD;
          if (rise[0])      pulse_d = 4'b0001;
          else if (rise[2]) pulse_d = 4'b0100;
          else if (rise[1]) pulse_d = 4'b0010;
          else              pulse_d = 4'b1000;
        end
      end
      ST_HOLD: begin
        if (stable_q == 4'b0000) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q      <= 4'b0000;
      sync2_q      <= 4'b0000;
      stable_q     <= 4'b0000;
      stable_dly_q <= 4'b0000;
      pulse_q      <= 4'b0000;
      state_q      <= ST_IDLE;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_dly_d;
      pulse_q      <= pulse_d;
      state_q      <= state_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign next_p    = pulse_q[0];
  assign hit_p     = pulse_q[1];
  assign stand_p   = pulse_q[2];
  assign double_p  = pulse_q[3];
  assign btn_level = stable_q;
  assign locked    = (state_q == ST_HOLD);

endmodule

// File: tb/tb_btn_conditioner.sv
module tb_btn_conditioner;

  localparam int DC = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       next_raw = 1'b0, hit_raw = 1'b0, stand_raw = 1'b0, double_raw = 1'b0;
  logic       next_p, hit_p, stand_p, double_p;
  logic [3:0] btn_level;
  logic       locked;

  int pass_cnt = 0;
  int total_cnt = 0;

  btn_conditioner #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk        (clk),
    .reset      (reset),
    .next_raw   (next_raw),
    .hit_raw    (hit_raw),
    .stand_raw  (stand_raw),
    .double_raw (double_raw),
    .next_p     (next_p),
    .hit_p      (hit_p),
    .stand_p    (stand_p),
    .double_p   (double_p),
    .btn_level  (btn_level),
    .locked     (locked)
  );

  always #5 clk = ~clk;

  // Reference model: history of raw samples per edge; a level is accepted
  // once the synchronised value (raw two edges back) has shown the opposite
  // level for DC consecutive edges.
  logic [3:0] samp [64];
  logic [3:0] stab [64];
  int         ec = 0;
  logic       m_locked = 1'b0;
  logic [3:0] m_pulse = 4'b0000;
  logic [3:0] m_level = 4'b0000;

  initial begin
    for (int i = 0; i < 64; i++) begin
      samp[i] = 4'b0000;
      stab[i] = 4'b0000;
    end
  end

  function automatic logic [3:0] pick(input logic [3:0] r);
    if (r[0]) return 4'b0001;
    if (r[2]) return 4'b0100;
    if (r[1]) return 4'b0010;
    if (r[3]) return 4'b1000;
    return 4'b0000;
  endfunction

  task automatic model_edge();
    logic [3:0] prev, prev2, ns, rise;
    logic       all_opp;
    ec++;
    prev  = stab[(ec - 1) & 63];
    prev2 = stab[(ec - 2) & 63];
    if (reset) begin
      samp[ec & 63]       = 4'b0000;
      samp[(ec - 1) & 63] = 4'b0000;
      stab[ec & 63]       = 4'b0000;
      m_locked = 1'b0;
      m_pulse  = 4'b0000;
    end else begin
      samp[ec & 63] = {double_raw, stand_raw, hit_raw, next_raw};
      ns = prev;
      for (int b = 0; b < 4; b++) begin
        all_opp = 1'b1;
        for (int i = 0; i < DC; i++)
          if (samp[(ec - 2 - i) & 63][b] == prev[b]) all_opp = 1'b0;
        if (all_opp) ns[b] = ~prev[b];
      end
      stab[ec & 63] = ns;
      rise = prev & ~prev2;
      m_pulse = 4'b0000;
      if (!m_locked) begin
        if (rise != 4'b0000) begin
          m_pulse  = pick(rise);
          m_locked = 1'b1;
        end
      end else if (prev == 4'b0000) begin
        m_locked = 1'b0;
      end
    end
    m_level = stab[ec & 63];
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  function automatic logic [8:0] dut_vec();
    return {double_p, stand_p, hit_p, next_p, btn_level, locked};
  endfunction

  function automatic logic [8:0] mdl_vec();
    return {m_pulse, m_level, m_locked};
  endfunction

  task automatic settle();
    {double_raw, stand_raw, hit_raw, next_raw} = 4'b0000;
    reset = 1'b0;
    repeat (20) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    {double_raw, stand_raw, hit_raw, next_raw} = 4'b1111;
    repeat (3) tick();
    total_cnt++;
    if (dut_vec() !== 9'b0) $display("FAIL reset_outputs got=%b exp=%b", dut_vec(), 9'b0);
    else pass_cnt++;
    total_cnt++;
    if (dut_vec() !== mdl_vec()) $display("FAIL reset_model got=%b exp=%b", dut_vec(), mdl_vec());
    else pass_cnt++;
    settle();
  endtask

  task automatic test_clean_press();
    int n_hit = 0, n_other = 0;
    logic [8:0] e;
    hit_raw = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      n_hit   += int'(hit_p);
      n_other += int'(next_p) + int'(stand_p) + int'(double_p);
      e = {1'b0, 1'b0, (k == 7), 1'b0, (k >= 6) ? 4'b0010 : 4'b0000, (k >= 7)};
      total_cnt++;
      if (dut_vec() !== e) $display("FAIL clean_press cyc=%0d got=%b exp=%b", k, dut_vec(), e);
      else pass_cnt++;
    end
    total_cnt++;
    if (n_hit !== 1 || n_other !== 0)
      $display("FAIL clean_press_count got hit=%0d other=%0d exp hit=1 other=0", n_hit, n_other);
    else pass_cnt++;
    settle();
    total_cnt++;
    if (locked !== 1'b0) $display("FAIL clean_release_unlock got=%b exp=0", locked);
    else pass_cnt++;
  endtask

  task automatic test_bounce();
    logic [0:4] pat;
    int n_next = 0, n_other = 0;
    pat = 5'b10101;
    for (int k = 1; k <= 20; k++) begin
      next_raw = (k <= 5) ? pat[k-1] : 1'b1;
      tick();
      n_next  += int'(next_p);
      n_other += int'(hit_p) + int'(stand_p) + int'(double_p);
      total_cnt++;
      if (next_p !== (k == 11)) $display("FAIL bounce_press cyc=%0d got=%b exp=%b", k, next_p, (k == 11));
      else pass_cnt++;
      total_cnt++;
      if (dut_vec() !== mdl_vec()) $display("FAIL bounce_model cyc=%0d got=%b exp=%b", k, dut_vec(), mdl_vec());
      else pass_cnt++;
    end
    for (int k = 1; k <= 20; k++) begin
      next_raw = (k <= 5) ? ~pat[k-1] : 1'b0;
      tick();
      n_next  += int'(next_p);
      n_other += int'(hit_p) + int'(stand_p) + int'(double_p);
      total_cnt++;
      if (dut_vec() !== mdl_vec()) $display("FAIL bounce_release cyc=%0d got=%b exp=%b", k, dut_vec(), mdl_vec());
      else pass_cnt++;
    end
    total_cnt++;
    if (n_next !== 1 || n_other !== 0 || locked !== 1'b0)
      $display("FAIL bounce_count got next=%0d other=%0d locked=%b exp 1 0 0", n_next, n_other, locked);
    else pass_cnt++;
    settle();
  endtask

  task automatic test_simultaneous();
    int n_stand = 0, n_hit = 0;
    stand_raw = 1'b1;
    hit_raw   = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      if (k == 16) stand_raw = 1'b0;
      if (k == 31) hit_raw = 1'b0;
      tick();
      n_stand += int'(stand_p);
      n_hit   += int'(hit_p);
      if (k == 7) begin
        total_cnt++;
        if ({double_p, stand_p, hit_p, next_p} !== 4'b0100)
          $display("FAIL simul_pulse got=%b exp=0100", {double_p, stand_p, hit_p, next_p});
        else pass_cnt++;
      end
      if (k >= 7 && k <= 30) begin
        total_cnt++;
        if (locked !== 1'b1) $display("FAIL simul_locked cyc=%0d got=%b exp=1", k, locked);
        else pass_cnt++;
      end
      total_cnt++;
      if (dut_vec() !== mdl_vec()) $display("FAIL simul_model cyc=%0d got=%b exp=%b", k, dut_vec(), mdl_vec());
      else pass_cnt++;
    end
    total_cnt++;
    if (n_stand !== 1 || n_hit !== 0 || locked !== 1'b0)
      $display("FAIL simul_count got stand=%0d hit=%0d locked=%b exp 1 0 0", n_stand, n_hit, locked);
    else pass_cnt++;
    settle();
  endtask

  task automatic test_lockout();
    int n_hit = 0, n_dbl = 0;
    hit_raw = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      if (k == 10) double_raw = 1'b1;
      if (k == 26) begin hit_raw = 1'b0; double_raw = 1'b0; end
      tick();
      n_hit += int'(hit_p);
      n_dbl += int'(double_p);
      total_cnt++;
      if (dut_vec() !== mdl_vec()) $display("FAIL lockout_model cyc=%0d got=%b exp=%b", k, dut_vec(), mdl_vec());
      else pass_cnt++;
    end
    total_cnt++;
    if (n_hit !== 1 || n_dbl !== 0)
      $display("FAIL lockout_count got hit=%0d double=%0d exp 1 0", n_hit, n_dbl);
    else pass_cnt++;
    double_raw = 1'b1;
    n_dbl = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      n_dbl += int'(double_p);
      total_cnt++;
      if (double_p !== (k == 7)) $display("FAIL lockout_fresh cyc=%0d got=%b exp=%b", k, double_p, (k == 7));
      else pass_cnt++;
    end
    total_cnt++;
    if (n_dbl !== 1) $display("FAIL lockout_fresh_count got=%0d exp=1", n_dbl);
    else pass_cnt++;
    settle();
  endtask

  task automatic test_glitch();
    double_raw = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      if (k == 4) double_raw = 1'b0;
      tick();
      total_cnt++;
      if (dut_vec() !== 9'b0) $display("FAIL glitch cyc=%0d got=%b exp=%b", k, dut_vec(), 9'b0);
      else pass_cnt++;
    end
    settle();
  endtask

  task automatic run_reset_mid(input int rst_edge, input int pulse_edge);
    int n_next = 0;
    next_raw = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      reset = (k == rst_edge);
      tick();
      n_next += int'(next_p);
      if (k == rst_edge) begin
        total_cnt++;
        if (dut_vec() !== 9'b0) $display("FAIL reset_mid_clear edge=%0d got=%b exp=%b", k, dut_vec(), 9'b0);
        else pass_cnt++;
      end
      total_cnt++;
      if (next_p !== (k == pulse_edge))
        $display("FAIL reset_mid_pulse rst=%0d cyc=%0d got=%b exp=%b", rst_edge, k, next_p, (k == pulse_edge));
      else pass_cnt++;
      total_cnt++;
      if (dut_vec() !== mdl_vec()) $display("FAIL reset_mid_model cyc=%0d got=%b exp=%b", k, dut_vec(), mdl_vec());
      else pass_cnt++;
    end
    reset = 1'b0;
    total_cnt++;
    if (n_next !== 1) $display("FAIL reset_mid_count rst=%0d got=%0d exp=1", rst_edge, n_next);
    else pass_cnt++;
    settle();
  endtask

  task automatic test_reset_mid();
    run_reset_mid(5, 12);
    run_reset_mid(7, 14);
  endtask

  task automatic test_random();
    int rem [4];
    logic [3:0] r;
    for (int b = 0; b < 4; b++) rem[b] = 1;
    r = 4'b0000;
    for (int k = 0; k < 3000; k++) begin
      for (int b = 0; b < 4; b++) begin
        rem[b]--;
        if (rem[b] <= 0) begin
          r[b] = ~r[b];
          rem[b] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : int'($urandom_range(5, 30));
        end
      end
      {double_raw, stand_raw, hit_raw, next_raw} = r;
      reset = ($urandom_range(0, 399) == 0);
      tick();
      total_cnt++;
      if (dut_vec() !== mdl_vec()) $display("FAIL random_model cyc=%0d got=%b exp=%b", k, dut_vec(), mdl_vec());
      else pass_cnt++;
      total_cnt++;
      if ($countones({double_p, stand_p, hit_p, next_p}) > 1)
        $display("FAIL random_onehot cyc=%0d got=%b exp=at most one", k, {double_p, stand_p, hit_p, next_p});
      else pass_cnt++;
    end
    settle();
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_lockout();
    test_glitch();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
